// File: rtl/bram_rd_pipe.sv
// Single-clock RAM with a byte-enable write port and a credit-gated read-request
// port. Read data returns in request order on a valid/ready stream.
module bram_rd_pipe #(
  parameter int DATA_WIDTH   = 64,
  parameter int DATA_DEPTH   = 1024,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
  parameter int NUM_BYTES    = DATA_WIDTH / 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [NUM_BYTES-1:0]                wr_be,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic                                rd_req_valid,
  output logic                                rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]               rd_req_addr,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic [$clog2(READ_LATENCY+3)-1:0]   inflight
);

  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_DEPTH);

  // Handshakes: a request moves when rd_req_valid && rd_req_ready; a response
  // moves when rd_valid && rd_ready. rd_valid/rd_data hold while stalled.

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic                  wr_in_range, rd_in_range, same_addr;
  logic                  accept, push, pop;
  logic [DATA_WIDTH-1:0] rd_sample;
  logic [READ_LATENCY-1:0] pipe_v;
  logic [DATA_WIDTH-1:0] pipe_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_cnt, inflight_q;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_in_range  = 32'(wr_addr) < DATA_DEPTH;
  assign rd_in_range  = 32'(rd_req_addr) < DATA_DEPTH;
  assign same_addr    = wr_en && rd_in_range && (wr_addr == rd_req_addr);
  assign rd_req_ready = inflight_q < CW'(FIFO_DEPTH);
  assign accept       = rd_req_valid && rd_req_ready;
  assign push         = pipe_v[READ_LATENCY-1];
  assign rd_valid     = fifo_cnt != '0;
  assign pop          = rd_valid && rd_ready;
  assign rd_data      = fifo_mem[rd_ptr];
  assign inflight     = inflight_q;

  // Write-first: enabled bytes of a same-cycle write replace the old RAM bytes.
  always_comb begin
    rd_sample = '0;
    if (rd_in_range) rd_sample = mem[rd_req_addr[IW-1:0]];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (same_addr && wr_be[i]) rd_sample[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) mem[wr_addr[IW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Data stages carry no reset; the valid bits alone decide what reaches the FIFO.
  always_ff @(posedge clk) begin
    pipe_d[0] <= rd_sample;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= pipe_d[READ_LATENCY-1];
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credit counts pipeline plus FIFO occupancy, so the FIFO can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_cnt == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_bram_rd_pipe.sv
// Directed bench for bram_rd_pipe: default build (latency 2) plus a latency-4,
// 11-bit-address build for the far end of the address range.
module tb_bram_rd_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en, rd_req_valid, rd_req_ready, rd_valid, rd_ready;
  logic [9:0]  wr_addr, rd_req_addr;
  logic [7:0]  wr_be;
  logic [63:0] wr_data, rd_data;
  logic [2:0]  inflight;

  logic        b_wr_en, b_rd_req_valid, b_rd_req_ready, b_rd_valid, b_rd_ready;
  logic [10:0] b_wr_addr, b_rd_req_addr;
  logic [7:0]  b_wr_be;
  logic [63:0] b_wr_data, b_rd_data;
  logic [2:0]  b_inflight;

  bram_rd_pipe dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .inflight(inflight)
  );

  bram_rd_pipe #(.READ_LATENCY(4), .ADDR_WIDTH(11)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be),
    .wr_data(b_wr_data), .rd_req_valid(b_rd_req_valid), .rd_req_ready(b_rd_req_ready),
    .rd_req_addr(b_rd_req_addr), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
    .rd_data(b_rd_data), .inflight(b_inflight)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {48'h5EED_0000_0000, 16'(i)};
  endfunction

  // All driver tasks start and end on a falling edge.
  task automatic write_word(input logic [9:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_one(input string tag, input logic [9:0] a, input logic [63:0] exp);
    int lat;
    rd_req_valid = 1'b1; rd_req_addr = a;
    check({tag, "_ready"}, 64'(rd_req_ready), 64'd1);
    @(negedge clk);
    rd_req_valid = 1'b0; wr_en = 1'b0;
    lat = 0;
    while (!rd_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_data"}, rd_data, exp);
    @(negedge clk);
  endtask

  int          acc, stale, lat;
  logic [10:0] b_addrs [2];
  logic [63:0] b_exp [2];

  initial begin
    wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
    rd_req_valid = 1'b1; rd_req_addr = 10'd3; rd_ready = 1'b1;
    b_wr_en = 0; b_wr_addr = 0; b_wr_be = 0; b_wr_data = 0;
    b_rd_req_valid = 0; b_rd_req_addr = 0; b_rd_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_data", rd_data, 64'd0);
    rst_n = 1'b1; rd_req_valid = 1'b0;
    check("rst_ready", 64'(rd_req_ready), 64'd1);
    repeat (4) @(negedge clk);
    check("drop_in_reset_valid", 64'(rd_valid), 64'd0);
    check("drop_in_reset_inflight", 64'(inflight), 64'd0);

    write_word(10'd5, 64'h1122334455667788, 8'hFF);
    read_one("basic", 10'd5, 64'h1122334455667788);

    write_word(10'd7, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    wr_en = 1'b1; wr_addr = 10'd7; wr_data = 64'h00000000000000FF; wr_be = 8'h01;
    read_one("fwd", 10'd7, 64'hAAAAAAAAAAAAAAFF);
    read_one("fwd_after", 10'd7, 64'hAAAAAAAAAAAAAAFF);

    // A write one cycle after accept must not leak into that response.
    rd_req_valid = 1'b1; rd_req_addr = 10'd7;
    @(negedge clk);
    rd_req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 10'd7; wr_data = 64'h0123456789ABCDEF; wr_be = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("snap_valid", 64'(rd_valid), 64'd1);
    check("snap_data", rd_data, 64'hAAAAAAAAAAAAAAFF);
    @(negedge clk);
    read_one("snap_new", 10'd7, 64'h0123456789ABCDEF);

    write_word(10'd9, 64'hDEADBEEF00C0FFEE, 8'hFF);
    write_word(10'd9, 64'h0, 8'h00);
    read_one("be_zero", 10'd9, 64'hDEADBEEF00C0FFEE);
    write_word(10'd9, 64'h1111111111111111, 8'hF0);
    read_one("be_upper", 10'd9, 64'h1111111100C0FFEE);

    for (int i = 0; i < 16; i++) write_word(10'(i), pat(i), 8'hFF);

    rd_ready = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 10'd0; acc = 0;
    repeat (8) begin
      if (rd_req_ready) acc++;
      @(negedge clk);
      rd_req_addr = 10'(acc);
    end
    rd_req_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd4);
    check("bp_ready_low", 64'(rd_req_ready), 64'd0);
    check("bp_inflight", 64'(inflight), 64'd4);
    check("bp_head", rd_data, pat(0));
    repeat (2) @(negedge clk);
    check("bp_hold_valid", 64'(rd_valid), 64'd1);
    check("bp_hold_data", rd_data, pat(0));
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_valid", 64'(rd_valid), 64'd1);
      check("bp_drain_data", rd_data, pat(i));
      @(negedge clk);
    end
    check("bp_empty", 64'(rd_valid), 64'd0);
    check("bp_resume", 64'(rd_req_ready), 64'd1);

    fork
      begin
        for (int i = 0; i < 16; i++) begin
          rd_req_valid = 1'b1; rd_req_addr = 10'(i);
          check("tp_ready", 64'(rd_req_ready), 64'd1);
          @(negedge clk);
        end
        rd_req_valid = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (!rd_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        for (int i = 0; i < 16; i++) begin
          check("tp_valid", 64'(rd_valid), 64'd1);
          check("tp_data", rd_data, pat(i));
          @(negedge clk);
        end
      end
    join
    check("tp_done", 64'(rd_valid), 64'd0);
    check("tp_inflight", 64'(inflight), 64'd0);

    rd_ready = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 10'd1;
    @(negedge clk);
    rd_req_addr = 10'd2;
    @(negedge clk);
    rd_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_valid", 64'(rd_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_inflight", 64'(inflight), 64'd0);
    check("mid_rst_data", rd_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rd_ready = 1'b1; stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (rd_valid) stale++;
    end
    check("post_rst_stale", 64'(stale), 64'd0);
    check("post_rst_ready", 64'(rd_req_ready), 64'd1);

    b_wr_en = 1'b1; b_wr_addr = 11'd1023; b_wr_data = 64'h0123456789ABCDEF; b_wr_be = 8'hFF;
    @(negedge clk);
    b_wr_addr = 11'd1024; b_wr_data = '1;
    @(negedge clk);
    b_wr_en = 1'b0;
    b_addrs[0] = 11'd1023; b_exp[0] = 64'h0123456789ABCDEF;
    b_addrs[1] = 11'd1024; b_exp[1] = 64'h0;
    for (int k = 0; k < 2; k++) begin
      b_rd_req_valid = 1'b1; b_rd_req_addr = b_addrs[k];
      check("b_ready", 64'(b_rd_req_ready), 64'd1);
      @(negedge clk);
      b_rd_req_valid = 1'b0;
      lat = 0;
      while (!b_rd_valid && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      check("b_lat", 64'(lat), 64'd4);
      check("b_data", b_rd_data, b_exp[k]);
      @(negedge clk);
    end
    check("b_inflight", 64'(b_inflight), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_rd_pipe.md
Name: bram_rd_pipe

Overview:
- Parametrised single-clock RAM with one write port and one read-request port. Generalises the existing fixed dual-port BRAM wrapper.
- Adds programmable read latency, byte-enable writes and same-cycle write-to-read forwarding.
- Read responses are returned on a valid/ready stream with backpressure, using credit-gated request acceptance into an internal response FIFO.
- Sits between packet/ARP/table logic and on-chip storage wherever a consumer can stall.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
- DATA_DEPTH, 1024, number of words.
- READ_LATENCY, 2, RAM read pipeline stages from request accept to FIFO write; legal range 1..4.
- ADDR_WIDTH, $clog2(DATA_DEPTH), address width.
- NUM_BYTES, DATA_WIDTH/8, byte-enable width (derived).
- FIFO_DEPTH, READ_LATENCY+2, response FIFO entries (localparam).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- wr_en  in  1  write strobe; always accepted.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  NUM_BYTES  byte enables; bit i enables wr_data[8i+7:8i].
- wr_data  in  DATA_WIDTH  write data.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted when high together with rd_req_valid.
- rd_req_addr  in  ADDR_WIDTH  read address.
- rd_valid  out  1  response valid.
- rd_ready  in  1  consumer ready.
- rd_data  out  DATA_WIDTH  response data.
- inflight  out  $clog2(FIFO_DEPTH+1)  pipeline entries plus FIFO entries (debug).

Behaviour:
- Reset (rst_n low, async) clears:
  - all pipeline valid bits and FIFO pointers;
  - inflight to 0, rd_valid to 0, rd_data to 0;
  - rd_req_ready to 1 once reset releases (combinational from credit).
- RAM contents are not reset and are undefined until written.
- A request arriving during reset is dropped. Reset mid-operation discards every outstanding response; no response is ever emitted for a pre-reset request.
- Write:
  - When wr_en is high, the enabled bytes are written at the clock edge. Disabled bytes are preserved.
  - wr_be = 0 is a no-op.
  - Out-of-range addresses (>= DATA_DEPTH) are ignored for writes.
- Credit:
  - rd_req_ready = (inflight < FIFO_DEPTH).
  - inflight increments on request accept and decrements on rd_valid && rd_ready. Both in the same cycle leave it unchanged.
- Read pipeline:
  - An accepted request samples the RAM at the accept edge.
  - Data enters the FIFO exactly READ_LATENCY cycles after accept.
  - If the FIFO was empty, rd_valid rises that same cycle (zero-latency FIFO bypass to output register). Minimum request-to-rd_valid latency is READ_LATENCY cycles.
  - Responses are strictly in request order.
- Forwarding (write-first):
  - If an accepted read and wr_en target the same address in the same cycle, each byte with wr_be[i]=1 returns the new wr_data byte; other bytes return the old RAM byte.
  - Writes after the accept cycle do not affect that response (snapshot semantics).
- Out-of-range read address returns all zeros.
- Output:
  - rd_data and rd_valid hold stable while rd_valid && !rd_ready. No data changes under stall.
- Throughput: with rd_ready held high, one request is accepted and one response delivered per cycle sustained, with no bubbles.
- FIFO overflow is impossible by construction. An assertion fires if a pipeline stage writes while the FIFO is full.
- Simultaneous accept and dequeue when inflight = FIFO_DEPTH is impossible, because rd_req_ready is low then.

Test Plan:
- Reset, then write addr 5 = 0x1122334455667788 with be=0xFF; read addr 5 -> rd_valid exactly 2 cycles after accept, rd_data = 0x1122334455667788.
- Addr 7 holds 0xAAAAAAAAAAAAAAAA; in one cycle, write addr 7 data 0x00000000000000FF with be=0x01 and accept a read of addr 7 -> response 0xAAAAAAAAAAAAAAFF. A following read also returns 0xAAAAAAAAAAAAAAFF.
- rd_ready held low, rd_req_valid held high -> exactly 4 requests accepted (FIFO_DEPTH=4), then rd_req_ready = 0 and inflight = 4. Release rd_ready -> 4 responses in address order, then acceptance resumes.
- Back-to-back reads of addrs 0..15 with rd_ready = 1 -> 16 consecutive rd_valid cycles, no bubbles, data in order.
- Two reads outstanding, assert rst_n low for 1 cycle -> rd_valid = 0 immediately (async), inflight = 0, no stale response ever emitted afterwards.
- READ_LATENCY=4 build: read of addr 1023 -> rd_valid 4 cycles after accept. Read of addr 1024 (ADDR_WIDTH=11 build) -> data 0.
